// File: rtl/keypad_entry_fsm.sv
// Keypad entry controller: decodes one-hot {row, col} key strobes into a BCD entry
// with backspace/clear/enter editing, and hands the finished entry off via valid/ready.
module keypad_entry_fsm #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              cur_key,
    input  logic                    strobe,
    input  logic                    entry_ready,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [3:0]              entry_len,
    output logic                    entry_valid,
    output logic [3:0]              last_key,
    output logic                    key_err,
    output logic                    busy
);

    localparam int         W       = 4 * MAX_DIGITS;
    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);
    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hE;
    localparam logic [3:0] KEY_ENT = 4'hF;
    // Nibble at index {row, col} is the hex code; row 0 is the top, col 0 the left.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    generate
        if (MAX_DIGITS < 1 || MAX_DIGITS > 8) begin : g_bad_max_digits
            $error("keypad_entry_fsm: MAX_DIGITS must be in 1..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ENTRY, SUBMIT} state_t;
    state_t state;

    logic [1:0] row_idx, col_idx;
    logic       row_ok, col_ok, key_ok, is_digit;
    logic [3:0] key_code;

    always_comb begin
        row_ok  = 1'b1;
        col_ok  = 1'b1;
        row_idx = 2'd0;
        col_idx = 2'd0;
        case (cur_key[7:4])
            4'b1000: row_idx = 2'd0;
            4'b0100: row_idx = 2'd1;
            4'b0010: row_idx = 2'd2;
            4'b0001: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
        case (cur_key[3:0])
            4'b1000: col_idx = 2'd0;
            4'b0100: col_idx = 2'd1;
            4'b0010: col_idx = 2'd2;
            4'b0001: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
        key_ok   = row_ok && col_ok;
        key_code = KEY_MAP[{row_idx, col_idx, 2'b00} +: 4];
        is_digit = (key_code <= 4'd9);
    end

    // NOTE: every register below is state, so only non-blocking assignments are used here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            entry_bcd   <= '0;
            entry_len   <= 4'd0;
            entry_valid <= 1'b0;
            busy        <= 1'b0;
            last_key    <= 4'd0;
            key_err     <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                SUBMIT: begin
                    // Strobes are ignored here; only the handshake moves us on.
                    if (entry_ready) begin
                        entry_bcd   <= '0;
                        entry_len   <= 4'd0;
                        entry_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    if (strobe) begin
                        if (!key_ok) begin
                            key_err <= 1'b1;
                        end else begin
                            last_key <= key_code;
                            // IDLE always holds len 0 and bcd 0, so IDLE and ENTRY share the editing paths.
                            if (is_digit) begin
                                if (entry_len == MAX_LEN) begin
                                    key_err <= 1'b1;
                                end else begin
                                    entry_bcd <= (entry_bcd << 4) | W'(key_code);
                                    entry_len <= entry_len + 4'd1;
                                    state     <= ENTRY;
                                end
                            end else if (key_code == KEY_BS) begin
                                if (state == ENTRY) begin
                                    entry_bcd <= entry_bcd >> 4;
                                    entry_len <= entry_len - 4'd1;
                                    if (entry_len == 4'd1)
                                        state <= IDLE;
                                end
                            end else if (key_code == KEY_CLR) begin
                                entry_bcd <= '0;
                                entry_len <= 4'd0;
                                state     <= IDLE;
                            end else if (key_code == KEY_ENT) begin
                                if (state == ENTRY) begin
                                    entry_valid <= 1'b1;
                                    busy        <= 1'b1;
                                    state       <= SUBMIT;
                                end else begin
                                    key_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_fsm.sv
// Scoreboard bench for keypad_entry_fsm: directed strobes push expected outputs,
// a negedge monitor pops and compares them and checks every handshake transfer.
module tb_keypad_entry_fsm;

    logic        clk;
    logic        rst;
    logic [7:0]  cur_key;
    logic        strobe;
    logic        entry_ready;
    logic [15:0] entry_bcd;
    logic [3:0]  entry_len;
    logic        entry_valid;
    logic [3:0]  last_key;
    logic        key_err;
    logic        busy;

    keypad_entry_fsm #(.MAX_DIGITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cur_key     (cur_key),
        .strobe      (strobe),
        .entry_ready (entry_ready),
        .entry_bcd   (entry_bcd),
        .entry_len   (entry_len),
        .entry_valid (entry_valid),
        .last_key    (last_key),
        .key_err     (key_err),
        .busy        (busy)
    );

    typedef struct {
        int          due;
        logic [26:0] val;   // {bcd, len, valid, busy, last_key, key_err}
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] sub_q[$];  // {bcd, len} expected at each transfer
    int          cyc;
    int          checks;
    int          errors;
    logic        prev_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: transfers are checked when valid && ready, per-cycle expectations when due.
    always @(negedge clk) begin
        if (entry_valid && entry_ready) begin
            if (sub_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_transfer: got bcd=%h len=%0d, expected no transfer",
                         entry_bcd, entry_len);
            end else begin
                check("transfer", {7'd0, entry_bcd, entry_len}, {7'd0, sub_q.pop_front()});
            end
        end
        while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {entry_bcd, entry_len, entry_valid, busy, last_key, key_err}, e.val);
        end
    end

    // One stimulus cycle; expected outputs are those seen after the next clock edge.
    task automatic step(input logic s, input logic [7:0] k, input logic r,
                        input logic [15:0] bcd, input logic [3:0] len, input logic v,
                        input logic [3:0] last, input logic err, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        strobe      = s;
        cur_key     = k;
        entry_ready = r;
        e.due  = cyc + 1;
        e.val  = {bcd, len, v, v, last, err};
        e.name = name;
        exp_q.push_back(e);
        if (v && !prev_v)
            sub_q.push_back({bcd, len});
        prev_v = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        prev_v      = 1'b0;
        rst         = 1'b1;
        strobe      = 1'b0;
        cur_key     = 8'h00;
        entry_ready = 1'b0;

        @(posedge clk);
        #1;
        e.due = cyc; e.val = '0; e.name = "reset_state";
        exp_q.push_back(e);
        #6;
        rst = 1'b0;

        //   s  key    rdy bcd       len  v  last  err  name
        // Digit entry and submit with ready held low
        step(1, 8'h84, 0, 16'h0002, 4'd1, 0, 4'h2, 0, "digit_2");
        step(1, 8'h14, 0, 16'h0020, 4'd2, 0, 4'h0, 0, "digit_0");
        step(1, 8'h44, 0, 16'h0205, 4'd3, 0, 4'h5, 0, "digit_5");
        step(1, 8'h12, 0, 16'h0205, 4'd3, 1, 4'hF, 0, "enter");
        step(0, 8'h00, 0, 16'h0205, 4'd3, 1, 4'hF, 0, "submit_hold");
        step(1, 8'h88, 0, 16'h0205, 4'd3, 1, 4'hF, 0, "submit_strobe_ignored");
        step(1, 8'hC4, 0, 16'h0205, 4'd3, 1, 4'hF, 0, "submit_bad_ignored");
        step(0, 8'h00, 1, 16'h0000, 4'd0, 0, 4'hF, 0, "transfer_done");
        // Overflow at MAX_DIGITS = 4
        step(1, 8'h88, 0, 16'h0001, 4'd1, 0, 4'h1, 0, "ovf_1");
        step(1, 8'h84, 0, 16'h0012, 4'd2, 0, 4'h2, 0, "ovf_2");
        step(1, 8'h82, 0, 16'h0123, 4'd3, 0, 4'h3, 0, "ovf_3");
        step(1, 8'h48, 0, 16'h1234, 4'd4, 0, 4'h4, 0, "ovf_4");
        step(1, 8'h44, 0, 16'h1234, 4'd4, 0, 4'h5, 1, "ovf_5_rejected");
        step(0, 8'h00, 0, 16'h1234, 4'd4, 0, 4'h5, 0, "ovf_err_one_cycle");
        // Backspace and clear
        step(1, 8'h81, 0, 16'h0000, 4'd0, 0, 4'hA, 0, "clear_full");
        step(1, 8'h28, 0, 16'h0007, 4'd1, 0, 4'h7, 0, "bs_digit_7");
        step(1, 8'h24, 0, 16'h0078, 4'd2, 0, 4'h8, 0, "bs_digit_8");
        step(1, 8'h18, 0, 16'h0007, 4'd1, 0, 4'hE, 0, "backspace_1");
        step(1, 8'h18, 0, 16'h0000, 4'd0, 0, 4'hE, 0, "backspace_to_idle");
        step(1, 8'h18, 0, 16'h0000, 4'd0, 0, 4'hE, 0, "backspace_in_idle");
        step(1, 8'h22, 0, 16'h0009, 4'd1, 0, 4'h9, 0, "digit_9");
        step(1, 8'h81, 0, 16'h0000, 4'd0, 0, 4'hA, 0, "clear");
        // Invalid and ignored input
        step(1, 8'hC4, 0, 16'h0000, 4'd0, 0, 4'hA, 1, "two_hot_row");
        step(1, 8'h00, 0, 16'h0000, 4'd0, 0, 4'hA, 1, "no_key_strobe");
        step(1, 8'h12, 0, 16'h0000, 4'd0, 0, 4'hF, 1, "enter_in_idle");
        step(0, 8'h00, 0, 16'h0000, 4'd0, 0, 4'hF, 0, "err_cleared");
        step(1, 8'h82, 0, 16'h0003, 4'd1, 0, 4'h3, 0, "digit_3");
        step(1, 8'h41, 0, 16'h0003, 4'd1, 0, 4'hB, 0, "key_b_no_edit");
        step(1, 8'h8C, 0, 16'h0003, 4'd1, 0, 4'hB, 1, "two_hot_col");
        step(1, 8'h81, 0, 16'h0000, 4'd0, 0, 4'hA, 0, "clear_again");
        // Back-to-back digits, then submit with ready already high
        step(1, 8'h82, 0, 16'h0003, 4'd1, 0, 4'h3, 0, "b2b_3");
        step(1, 8'h42, 0, 16'h0036, 4'd2, 0, 4'h6, 0, "b2b_6");
        step(1, 8'h12, 1, 16'h0036, 4'd2, 1, 4'hF, 0, "enter_ready_high");
        step(1, 8'h88, 1, 16'h0000, 4'd0, 0, 4'hF, 0, "strobe_on_transfer");
        step(0, 8'h00, 0, 16'h0000, 4'd0, 0, 4'hF, 0, "after_fast_transfer");
        // Reach SUBMIT holding 0x42, then reset between edges
        step(1, 8'h48, 0, 16'h0004, 4'd1, 0, 4'h4, 0, "rst_digit_4");
        step(1, 8'h84, 0, 16'h0042, 4'd2, 0, 4'h2, 0, "rst_digit_2");
        step(1, 8'h12, 0, 16'h0042, 4'd2, 1, 4'hF, 0, "rst_enter");
        step(0, 8'h00, 0, 16'h0042, 4'd2, 1, 4'hF, 0, "rst_in_submit");
        drain();
        #3;
        rst = 1'b1;
        sub_q.delete();
        prev_v = 1'b0;
        e.due = cyc; e.val = '0; e.name = "async_reset_mid_submit";
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 8'h00, 0, 16'h0000, 4'd0, 0, 4'h0, 0, "post_reset_idle");
        step(1, 8'h88, 0, 16'h0001, 4'd1, 0, 4'h1, 0, "post_reset_digit");
        step(0, 8'h00, 0, 16'h0001, 4'd1, 0, 4'h1, 0, "post_reset_hold");
        drain();
        @(posedge clk);

        if (exp_q.size() != 0 || sub_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queues_drained: got %0d expectations and %0d transfers pending, expected 0",
                     exp_q.size(), sub_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry_fsm.md
# keypad_entry_fsm

Consumer end of the 4x4 keypad scan interface. Takes the one-hot `{row, col}` key code and the single-cycle key strobe from the keypad scanner, and decodes each press into a key value. Builds a multi-digit BCD entry with backspace, clear and enter editing. Presents the finished entry to downstream logic through a valid/ready handshake.

## Interface
- `MAX_DIGITS`, 4, maximum number of BCD digits held in one entry (1..8).
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `cur_key`  input  8  key code; bits [7:4] are the one-hot row (4'b1000 = top), bits [3:0] are the one-hot column (4'b1000 = left); 8'd0 means no key.
- `strobe`  input  1  one-cycle pulse per new key press; `cur_key` is valid in the same cycle.
- `entry_ready`  input  1  downstream accepts the entry when high while `entry_valid` is high.
- `entry_bcd`  output  4*MAX_DIGITS  entry digits; the most recent digit is in [3:0]; unused upper digits are 0.
- `entry_len`  output  4  number of digits currently held (0..MAX_DIGITS).
- `entry_valid`  output  1  a submitted entry is held and awaiting `entry_ready`.
- `last_key`  output  4  hex code of the last valid decoded key.
- `key_err`  output  1  one-cycle pulse for a rejected press.
- `busy`  output  1  high in SUBMIT.

## Operation
- Key map by row, left to right:
  - Row 1: 1 2 3 A.
  - Row 2: 4 5 6 B.
  - Row 3: 7 8 9 C.
  - Row 4: * 0 # D.
- Hex codes: digits map to 0x0–0x9; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- Key roles: `*` is backspace, `#` is enter, `A` is clear. `B`, `C` and `D` are decoded and latched into `last_key` but have no editing effect.
- Decode is valid only when both nibbles of `cur_key` are exactly one-hot. Any other code with `strobe` high is rejected: `key_err` pulses and nothing else changes, including `last_key`.
- States: IDLE (`entry_len`=0), ENTRY (1..MAX_DIGITS digits), SUBMIT (`entry_valid`=1).
- Cycles where `strobe` is low: no change, except the handshake.
- **IDLE**:
  - Digit: shift in at [3:0], `entry_len`=1, go to ENTRY.
  - `#`: `key_err` pulses, stay in IDLE.
  - `*` or `A`: no-op, no error.
- **ENTRY**:
  - Digit: shift `entry_bcd` left by 4 and insert the digit at [3:0], `entry_len`+1.
  - Digit when `entry_len`==MAX_DIGITS: rejected, `key_err` pulses, contents unchanged.
  - `*`: shift right by 4 (the top digit becomes 0), `entry_len`-1; go to IDLE when `entry_len` reaches 0.
  - `A`: clear `entry_bcd` and `entry_len` to 0, go to IDLE.
  - `#`: go to SUBMIT; `entry_bcd` and `entry_len` freeze.
- **SUBMIT**:
  - `entry_valid`=1 and `busy`=1.
  - All strobes are ignored: no decode, no `last_key` update, no `key_err`.
  - Transfer happens on a cycle with `entry_valid` && `entry_ready` high. Next cycle: `entry_bcd`=0, `entry_len`=0, state IDLE, `entry_valid`=0.
  - `entry_valid` never drops without a transfer.
- `entry_len` width is fixed at 4 bits; MAX_DIGITS > 8 is illegal (elaboration assertion).

## Timing
- All outputs are registered.
- Effects of a strobe at edge N (`entry_bcd`, `entry_len`, `last_key`, `key_err`, state) are visible after edge N+1, i.e. 1-cycle latency.
- `key_err` is high for exactly the one cycle after the rejected strobe.
- `#` strobed at edge N: `entry_valid` is high from N+1. With `entry_ready` tied high, the transfer completes at edge N+1 and `entry_valid` is low again after edge N+2. Minimum `entry_valid` pulse is 1 cycle.
- `entry_ready` may be high before `entry_valid` rises; no combinational path from `entry_ready` to `entry_valid`.
- A strobe coinciding with the transfer cycle is ignored, because the block is still in SUBMIT.
- Back-to-back strobes on consecutive cycles must each be processed.
- Reset, any time including mid-entry or mid-SUBMIT, gives immediately:
  - state IDLE;
  - `entry_bcd`=0, `entry_len`=0;
  - `entry_valid`=0, `busy`=0, `key_err`=0;
  - `last_key`=0.

## Test plan
- **Digit entry and submit.** Strobe codes 8'b1000_0100 ("2"), 8'b0001_0100 ("0"), 8'b0100_0010 ("5"), then `#` (8'b0001_0010) with `entry_ready`=0 → `entry_bcd`=16'h0205, `entry_len`=3, `entry_valid` stays high. Then `entry_ready`=1 for one cycle → transfer; the next cycle shows `entry_len`=0 and `entry_valid`=0.
- **Overflow.** MAX_DIGITS=4, strobe digits 1,2,3,4,5 → `entry_bcd`=16'h1234, `entry_len`=4, `key_err` pulses once after the fifth strobe.
- **Backspace and clear.** Enter 7,8, then `*` → `entry_bcd`=16'h0007, `entry_len`=1. Another `*` → IDLE, `entry_len`=0. Enter 9, then `A` (8'b1000_0001) → `entry_bcd`=0, IDLE, `last_key`=4'hA.
- **Invalid and ignored input.** Strobe 8'b1100_0100 → `key_err` pulses, `last_key` unchanged. `#` in IDLE → `key_err` pulses. `B` in ENTRY → `last_key`=4'hB, entry unchanged. Any strobe during SUBMIT → no change at all.
- **Reset mid-operation.** Assert `rst` asynchronously between clock edges while in SUBMIT with `entry_bcd`=16'h0042 → all outputs are 0 before the next edge, and the block is in IDLE after release.
- **Back-to-back strobes.** Digits 3 and 6 on consecutive cycles → `entry_bcd`=16'h0036, `entry_len`=2.
